// File: rtl/traffic_timer_pkg.sv
// Shared encodings for the traffic light controllers and their timer.
package traffic_timer_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } light_e;

  typedef enum logic [1:0] {
    PH_RUN   = 2'd0,
    PH_SHORT = 2'd1,
    PH_LONG  = 2'd2
  } phase_e;

  // Prescaler width, kept at least one bit so PRESCALE=1 still elaborates.
  function automatic int prescale_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/traffic_timer_tick_gen.sv
// tick_gen: divides clk down to one tick every PRESCALE cycles.
// A clear restarts the division so the first tick after a timer restart
// lands a full PRESCALE cycles later.
module tick_gen
  import traffic_timer_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int             PW   = prescale_w(PRESCALE);
  localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  // Free-running modulo-PRESCALE counter, zeroed by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clear || (pre == LAST)) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  assign tick = (pre == LAST);

endmodule

// File: rtl/traffic_timer.sv
// traffic_timer: elapsed-tick counter with short/long timeout phases for
// the highway/farmway light controllers.
// Optional macro TIMER_PRESCALE_EN: divide clk by PRESCALE to form ticks.
//
// State    | meaning
// PH_RUN   | fewer than SHORT_CNT ticks since restart
// PH_SHORT | at least SHORT_CNT, fewer than LONG_CNT ticks
// PH_LONG  | at least LONG_CNT ticks; count saturated
module traffic_timer
  import traffic_timer_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int SHORT_CNT = 3,
  parameter int LONG_CNT  = 15,
  parameter int PRESCALE  = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_hw_reset,
  input  logic             timer_fw_reset,
  output logic             short_timeout,
  output logic             long_timeout,
  output logic [CNT_W-1:0] count
);

  if (!((SHORT_CNT > 0) && (SHORT_CNT < LONG_CNT) &&
        (longint'(LONG_CNT) < (longint'(1) << CNT_W)) && (PRESCALE > 0)))
  begin : g_param_check
    $error("traffic_timer: illegal SHORT_CNT/LONG_CNT/CNT_W/PRESCALE");
  end

  localparam logic [CNT_W-1:0] SHORT_V = CNT_W'(SHORT_CNT);
  localparam logic [CNT_W-1:0] LONG_V  = CNT_W'(LONG_CNT);

  logic             req;
  logic             tick;
  phase_e           phase;
  phase_e           phase_next;
  logic [CNT_W-1:0] count_next;

  assign req = timer_hw_reset | timer_fw_reset;

`ifdef TIMER_PRESCALE_EN
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (req),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Count and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= PH_RUN;
    end else begin
      count <= count_next;
      phase <= phase_next;
    end
  end

  // Restart beats increment; phase advances on the edge the count hits a threshold.
  always_comb begin
    count_next = count;
    phase_next = phase;
    if (req) begin
      count_next = '0;
      phase_next = PH_RUN;
    end else if (tick) begin
      if (count != LONG_V) begin
        count_next = count + CNT_W'(1);
      end
      case (phase)
        PH_RUN:   if (count_next == SHORT_V) phase_next = PH_SHORT;
        PH_SHORT: if (count_next == LONG_V)  phase_next = PH_LONG;
        default:  ;
      endcase
    end
  end

  assign short_timeout = (phase != PH_RUN);
  assign long_timeout  = (phase == PH_LONG);

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer; works with or without
// TIMER_PRESCALE_EN (PRESCALE is set to 4 on the instance).
module tb_traffic_timer;

`ifdef TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       timer_hw_reset;
  logic       timer_fw_reset;
  logic       short_timeout;
  logic       long_timeout;
  logic [7:0] count;

  typedef struct {
    logic [7:0] cnt;
    logic       sh;
    logic       lg;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   m_cnt    = 0;
  int   m_pre    = 0;

  traffic_timer #(
    .CNT_W     (8),
    .SHORT_CNT (3),
    .LONG_CNT  (15),
    .PRESCALE  (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .timer_hw_reset (timer_hw_reset),
    .timer_fw_reset (timer_fw_reset),
    .short_timeout  (short_timeout),
    .long_timeout   (long_timeout),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of requests at the falling edge, push the expected
  // post-edge result, then move to just after the rising edge.
  task automatic drive(input logic hw, input logic fw);
    exp_t x;
    @(negedge clk);
    timer_hw_reset = hw;
    timer_fw_reset = fw;
    if (hw || fw) begin
      m_cnt = 0;
      m_pre = 0;
    end else if (m_pre == P - 1) begin
      m_pre = 0;
      if (m_cnt < 15) m_cnt++;
    end else begin
      m_pre++;
    end
    x.cnt = 8'(m_cnt);
    x.sh  = (m_cnt >= 3);
    x.lg  = (m_cnt >= 15);
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    timer_hw_reset = 1'b0;
    timer_fw_reset = 1'b0;
    #12;
    checks++;
    if ({count, short_timeout, long_timeout} !== {8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: got count=%0d short=%b long=%b want 0 0 0",
               count, short_timeout, long_timeout);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cnt = 0;
    m_pre = 0;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 16 * P + 4; i++) begin
      drive(1'b0, 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({count, short_timeout, long_timeout} !== {e.cnt, e.sh, e.lg}) begin
        failures++;
        $display("FAIL free_run cyc %0d: got count=%0d short=%b long=%b want %0d %b %b",
                 i, count, short_timeout, long_timeout, e.cnt, e.sh, e.lg);
      end
    end
  endtask

  task automatic test_long_restart();
    // A request pulse between edges must not reach the outputs.
    #2;
    timer_hw_reset = 1'b1;
    #1;
    checks++;
    if ({short_timeout, long_timeout} !== 2'b11) begin
      failures++;
      $display("FAIL no_comb_path: got short=%b long=%b want 1 1",
               short_timeout, long_timeout);
    end
    timer_hw_reset = 1'b0;
    drive(1'b1, 1'b0);
    for (int i = 0; i < 3 * P + 2; i++) begin
      if (i > 0) drive(1'b0, 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({count, short_timeout, long_timeout} !== {e.cnt, e.sh, e.lg}) begin
        failures++;
        $display("FAIL long_restart cyc %0d: got count=%0d short=%b long=%b want %0d %b %b",
                 i, count, short_timeout, long_timeout, e.cnt, e.sh, e.lg);
      end
    end
  endtask

  task automatic test_dual_req();
    int guard = 0;
    while (m_cnt != 7 && guard < 200) begin
      drive(1'b0, 1'b0);
      void'(sbq.pop_front());
      guard++;
    end
    checks++;
    if (count !== 8'd7) begin
      failures++;
      $display("FAIL dual_req setup: got count=%0d want 7", count);
    end
    drive(1'b1, 1'b1);
    for (int i = 0; i < 2 * P + 1; i++) begin
      if (i > 0) drive(1'b0, 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({count, short_timeout, long_timeout} !== {e.cnt, e.sh, e.lg}) begin
        failures++;
        $display("FAIL dual_req cyc %0d: got count=%0d short=%b long=%b want %0d %b %b",
                 i, count, short_timeout, long_timeout, e.cnt, e.sh, e.lg);
      end
    end
  endtask

  task automatic test_held_req();
    for (int i = 0; i < 5 + 4 * P; i++) begin
      drive((i < 5), 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({count, short_timeout, long_timeout} !== {e.cnt, e.sh, e.lg}) begin
        failures++;
        $display("FAIL held_req cyc %0d: got count=%0d short=%b long=%b want %0d %b %b",
                 i, count, short_timeout, long_timeout, e.cnt, e.sh, e.lg);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1);
    void'(sbq.pop_front());
    for (int i = 0; i < 10 * P; i++) begin
      drive(1'b0, 1'b0);
      void'(sbq.pop_front());
    end
    checks++;
    if ({count, short_timeout} !== {8'd10, 1'b1}) begin
      failures++;
      $display("FAIL async_reset setup: got count=%0d short=%b want 10 1",
               count, short_timeout);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({count, short_timeout, long_timeout} !== {8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got count=%0d short=%b long=%b want 0 0 0",
               count, short_timeout, long_timeout);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cnt = 0;
    m_pre = 0;
    for (int i = 0; i < 4 * P; i++) begin
      drive(1'b0, 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({count, short_timeout, long_timeout} !== {e.cnt, e.sh, e.lg}) begin
        failures++;
        $display("FAIL after_reset cyc %0d: got count=%0d short=%b long=%b want %0d %b %b",
                 i, count, short_timeout, long_timeout, e.cnt, e.sh, e.lg);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3 + 4 * P; i++) begin
      drive((i == 0) || (i == 2), (i == 1));
      e = sbq.pop_front();
      checks++;
      if ({count, short_timeout, long_timeout} !== {e.cnt, e.sh, e.lg}) begin
        failures++;
        $display("FAIL back_to_back cyc %0d: got count=%0d short=%b long=%b want %0d %b %b",
                 i, count, short_timeout, long_timeout, e.cnt, e.sh, e.lg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_long_restart();
    test_dual_req();
    test_held_req();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the counter width in bits.
REQ-002 Parameter SHORT_CNT, default 3, SHALL set the short-timeout threshold in ticks.
REQ-003 Parameter LONG_CNT, default 15, SHALL set the long-timeout threshold in ticks.
REQ-004 Parameter PRESCALE, default 50, SHALL set the clk cycles per tick; it is used only when TIMER_PRESCALE_EN is defined.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-007 Port timer_hw_reset, input, 1 bit, SHALL be the timer restart request from the highway light controller.
REQ-008 Port timer_fw_reset, input, 1 bit, SHALL be the timer restart request from the farmway light controller.
REQ-009 Port short_timeout, output, 1 bit, SHALL be a level signal meaning at least SHORT_CNT ticks have elapsed since the last restart.
REQ-010 Port long_timeout, output, 1 bit, SHALL be a level signal meaning at least LONG_CNT ticks have elapsed since the last restart.
REQ-011 Port count, output, CNT_W bits, SHALL be the current elapsed-tick value, for debug and observation.

Function
REQ-012 A restart request SHALL be the OR of timer_hw_reset and timer_fw_reset; both asserted together SHALL behave as a single request.
REQ-013 A restart request sampled at edge E SHALL set count to 0, clear the prescaler and set phase to PH_RUN, all at edge E.
REQ-014 A restart request SHALL take priority over the increment at the same edge.
REQ-015 With no request, count SHALL increment by 1 per tick and saturate at LONG_CNT, never wrapping.
REQ-016 Without TIMER_PRESCALE_EN, one tick SHALL occur every clk cycle.
REQ-017 The phase register SHALL hold one of three states: PH_RUN, PH_SHORT or PH_LONG.
REQ-018 Phase SHALL move PH_RUN->PH_SHORT at the edge where count becomes SHORT_CNT.
REQ-019 Phase SHALL move PH_SHORT->PH_LONG at the edge where count becomes LONG_CNT.
REQ-020 Phase SHALL return from any state to PH_RUN only on a restart request.
REQ-021 short_timeout SHALL equal (phase != PH_RUN), and long_timeout SHALL equal (phase == PH_LONG).
REQ-022 Both outputs SHALL be decoded from registers only, with no combinational path from either request input, because the controllers derive their requests from these timeouts.
REQ-023 Latency without prescale: a request at edge E SHALL give short_timeout high after edge E+SHORT_CNT and long_timeout high after edge E+LONG_CNT.
REQ-024 The module SHALL reject, at elaboration, parameter sets violating 0 < SHORT_CNT < LONG_CNT < 2^CNT_W.

Reset
REQ-025 On rst_n low, count SHALL be 0, the prescaler SHALL be 0, phase SHALL be PH_RUN, and short_timeout and long_timeout SHALL both be 0, asynchronously.
REQ-026 After rst_n deasserts, counting SHALL start at the first rising clk edge as if a restart had just occurred.
REQ-027 rst_n asserted mid-count SHALL abandon the count immediately, with no residual timeout.

Configuration
REQ-028 With macro TIMER_PRESCALE_EN defined, a prescaler counter of $clog2(PRESCALE) bits SHALL produce one tick every PRESCALE clk cycles, and every threshold SHALL be counted in ticks.
REQ-029 With TIMER_PRESCALE_EN undefined, the prescaler logic SHALL be absent, tick SHALL be constant 1, and PRESCALE SHALL be ignored.

Structure
REQ-030 Phase encodings PH_RUN=2'd0, PH_SHORT=2'd1 and PH_LONG=2'd2 SHALL live in the shared traffic package, alongside the light-state encodings RED, GREEN and YELLOW.
REQ-031 The prescaler SHALL be a sub-module named tick_gen, instantiated only under TIMER_PRESCALE_EN; the counter and phase logic SHALL stay in traffic_timer.

Verification
REQ-032 Reset then free run, default parameters, no prescale -> short_timeout rises after the 3rd edge, long_timeout after the 15th edge, and count holds at 15 from then on.
REQ-033 timer_hw_reset pulsed for one cycle while in PH_LONG -> at that edge count=0 and both timeouts go low; short_timeout is high again 3 edges later.
REQ-034 timer_hw_reset and timer_fw_reset asserted in the same cycle at count=7 -> a single restart, with count=0 at the next edge.
REQ-035 Restart request held high for 5 cycles -> count stays 0 and both timeouts stay low throughout; counting resumes on the first edge after release.
REQ-036 rst_n pulsed low asynchronously between edges while count=10 -> count, short_timeout and long_timeout go to 0 immediately, without waiting for clk.
REQ-037 Build with TIMER_PRESCALE_EN and PRESCALE=4 -> short_timeout rises 12 edges and long_timeout 60 edges after restart.
